// File: rtl/mem_arbiter.sv
// Arbitrates a read engine and a write engine onto one Avalon-MM master port,
// tracking outstanding pipelined reads and returning their data in order.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshakes: a requester holds req (and its address/data) until the
    // matching one-cycle grant; a master command is accepted on the rising
    // edge where it is high and master_waitrequest is low.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CMD = 2'd1,
        WR_CMD = 2'd2
    } state_t;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t            state, state_nxt;
    logic [3:0]        outstanding, outstanding_nxt;
    logic              last_wr, last_wr_nxt;
    logic              err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              read_nxt, write_nxt;
    logic              rd_grant_nxt, wr_grant_nxt;
    logic              rd_elig, wr_elig, rd_accept;

    // A requester whose grant is pulsing still holds req this cycle; ignore it
    // so the same request is not issued twice.
    assign rd_elig   = rd_req && !rd_grant && (outstanding < MAX_OUT);
    assign wr_elig   = wr_req && !wr_grant;
    assign rd_accept = (state == RD_CMD) && !master_waitrequest;

    assign busy      = (state != IDLE) || (outstanding != 4'd0);
    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        addr_nxt     = master_address;
        wdata_nxt    = master_writedata;
        read_nxt     = master_read;
        write_nxt    = master_write;
        rd_grant_nxt = 1'b0;
        wr_grant_nxt = 1'b0;
        last_wr_nxt  = last_wr;
        case (state)
            IDLE: begin
                // last_wr is clear after reset, so a tie goes to the write first.
                if (rd_elig && (!wr_elig || last_wr)) begin
                    state_nxt = RD_CMD;
                    read_nxt  = 1'b1;
                    addr_nxt  = rd_addr;
                    wdata_nxt = '0;
                end else if (wr_elig) begin
                    state_nxt = WR_CMD;
                    write_nxt = 1'b1;
                    addr_nxt  = wr_addr;
                    wdata_nxt = wr_data;
                end
            end
            RD_CMD: begin
                if (!master_waitrequest) begin
                    state_nxt    = IDLE;
                    read_nxt     = 1'b0;
                    addr_nxt     = '0;
                    wdata_nxt    = '0;
                    rd_grant_nxt = 1'b1;
                    last_wr_nxt  = 1'b0;
                end
            end
            WR_CMD: begin
                if (!master_waitrequest) begin
                    state_nxt    = IDLE;
                    write_nxt    = 1'b0;
                    addr_nxt     = '0;
                    wdata_nxt    = '0;
                    wr_grant_nxt = 1'b1;
                    last_wr_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
                addr_nxt  = '0;
                wdata_nxt = '0;
            end
        endcase
    end

    always_comb begin
        outstanding_nxt = outstanding;
        err_nxt         = err;
        if (rd_accept && !master_readdatavalid) begin
            outstanding_nxt = outstanding + 4'd1;
        end else if (!rd_accept && master_readdatavalid && (outstanding != 4'd0)) begin
            outstanding_nxt = outstanding - 4'd1;
        end
        // A response nobody is waiting for is a sticky protocol error.
        if (master_readdatavalid && (outstanding == 4'd0)) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            outstanding      <= 4'd0;
            last_wr          <= 1'b0;
            err              <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            rd_grant         <= 1'b0;
            wr_grant         <= 1'b0;
            rd_data          <= '0;
            rd_data_valid    <= 1'b0;
        end else begin
            state            <= state_nxt;
            outstanding      <= outstanding_nxt;
            last_wr          <= last_wr_nxt;
            err              <= err_nxt;
            master_address   <= addr_nxt;
            master_writedata <= wdata_nxt;
            master_read      <= read_nxt;
            master_write     <= write_nxt;
            rd_grant         <= rd_grant_nxt;
            wr_grant         <= wr_grant_nxt;
            rd_data_valid    <= master_readdatavalid;
            if (master_readdatavalid) begin
                rd_data <= master_readdata;
            end
        end
    end

endmodule
